preamble_sync_ctrl: RTL and testbench



---
 rtl/preamble_sync_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_preamble_sync_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preamble_sync_ctrl.sv
// Sequencing controller around the long-preamble detector: gates short-preamble
// triggers, times out idle searches, frames the detector output and holds off re-arming.
module preamble_sync_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] frame_len,
  input  logic [CNT_WIDTH-1:0] timeout,
  input  logic [CNT_WIDTH-1:0] holdoff,
  input  logic [WIDTH-1:0]     s_tdata,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [WIDTH-1:0]     d_tdata,
  output logic                 d_tlast,
  output logic                 d_tvalid,
  input  logic                 d_tready,
  input  logic [WIDTH-1:0]     r_tdata,
  input  logic                 r_tlast,
  input  logic                 r_tvalid,
  output logic                 r_tready,
  output logic [WIDTH-1:0]     o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 locked,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] lock_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FRAME, S_HOLDOFF} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_beat_cnt, w_beat_nxt;
  logic [CNT_WIDTH-1:0] r_flen, w_flen_nxt;
  logic [CNT_WIDTH-1:0] r_lock_cnt, r_miss_cnt;
  logic [CNT_WIDTH-1:0] w_flen_sel;
  logic                 w_in_frame, w_r_beat, w_o_hs, w_s_trig;
  logic                 w_lock_inc, w_miss_inc;

  assign w_flen_sel = (frame_len == '0) ? ONE : frame_len;
  assign w_in_frame = (r_state == S_FRAME) | ((r_state == S_ARMED) & r_tlast);

  assign d_tdata  = s_tdata;
  assign d_tvalid = s_tvalid;
  assign s_tready = d_tready;
  assign d_tlast  = s_tlast & enable & (r_state == S_IDLE);

  // Outside a frame the return stream is drained and discarded.
  assign o_tdata  = r_tdata;
  assign o_tvalid = w_in_frame & r_tvalid;
  assign r_tready = w_in_frame ? o_tready : 1'b1;

  assign w_r_beat = r_tvalid & r_tready;
  assign w_o_hs   = o_tvalid & o_tready;
  assign w_s_trig = s_tvalid & s_tready & s_tlast & enable;

  assign locked   = (r_state == S_FRAME);
  assign busy     = (r_state != S_IDLE);
  assign lock_cnt = r_lock_cnt;
  assign miss_cnt = r_miss_cnt;

  // Last-sample flag: from the latched length in FRAME, from the live length on a one-beat lock.
  always_comb begin
    o_tlast = 1'b0;
    if (r_state == S_FRAME) begin
      o_tlast = (r_beat_cnt == r_flen - ONE) & o_tvalid;
    end else if (r_state == S_ARMED) begin
      o_tlast = r_tlast & (w_flen_sel == ONE) & o_tvalid;
    end else begin
      o_tlast = 1'b0;
    end
  end

  // Next-state and beat counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_flen_nxt  = r_flen;
    w_lock_inc  = 1'b0;
    w_miss_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_s_trig) begin
          w_state_nxt = S_ARMED;
          w_beat_nxt  = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARMED: begin
        // A lock beat takes priority over both enable drop and timeout.
        if (w_r_beat && r_tlast) begin
          w_lock_inc = 1'b1;
          w_flen_nxt = w_flen_sel;
          if (w_flen_sel == ONE) begin
            w_state_nxt = S_HOLDOFF;
            w_beat_nxt  = '0;
          end else begin
            w_state_nxt = S_FRAME;
            w_beat_nxt  = ONE;
          end
        end else if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_r_beat) begin
          if ((timeout == '0) || (r_beat_cnt == timeout - ONE)) begin
            w_miss_inc  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_nxt = r_beat_cnt + ONE;
          end
        end else begin
          w_state_nxt = S_ARMED;
        end
      end
      S_FRAME: begin
        if (w_o_hs && o_tlast) begin
          w_state_nxt = S_HOLDOFF;
          w_beat_nxt  = '0;
        end else if (w_o_hs) begin
          w_beat_nxt = r_beat_cnt + ONE;
        end else begin
          w_state_nxt = S_FRAME;
        end
      end
      S_HOLDOFF: begin
        if (holdoff == '0) begin
          w_state_nxt = S_IDLE;
        end else if (w_r_beat) begin
          if (r_beat_cnt == holdoff - ONE) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_nxt = r_beat_cnt + ONE;
          end
        end else begin
          w_state_nxt = S_HOLDOFF;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  // State, beat counter and latched frame length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_flen     <= ONE;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_flen     <= w_flen_nxt;
    end
  end

  // Saturating statistics; clear beats a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_cnt <= '0;
      r_miss_cnt <= '0;
    end else if (clear) begin
      r_lock_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_lock_inc && (r_lock_cnt != '1)) begin
        r_lock_cnt <= r_lock_cnt + ONE;
      end
      if (w_miss_inc && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_preamble_sync_ctrl.sv
// Bench for preamble_sync_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a countdown-style transaction model.
module tb_preamble_sync_ctrl;
  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, enable, clear;
  logic [CW-1:0] frame_len, timeout, holdoff;
  logic [W-1:0]  s_tdata, d_tdata, r_tdata, o_tdata;
  logic          s_tlast, s_tvalid, s_tready;
  logic          d_tlast, d_tvalid, d_tready;
  logic          r_tlast, r_tvalid, r_tready;
  logic          o_tlast, o_tvalid, o_tready;
  logic          locked, busy;
  logic [CW-1:0] lock_cnt, miss_cnt;

  preamble_sync_ctrl #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .frame_len(frame_len), .timeout(timeout), .holdoff(holdoff),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .d_tdata(d_tdata), .d_tlast(d_tlast), .d_tvalid(d_tvalid), .d_tready(d_tready),
    .r_tdata(r_tdata), .r_tlast(r_tlast), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .locked(locked), .busy(busy), .lock_cnt(lock_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: searching flag with beats-left countdown, frame samples left, holdoff beats left.
  bit m_search, m_hold;
  int m_search_left, m_frame_left, m_hold_left, m_lock, m_miss;
  bit p_rbeat, p_shs;

  int          obs_obeats, obs_olast, obs_olast_idx, obs_order_bad;
  logic [W-1:0] obs_first, obs_prev;
  bit          obs_dtlast, last_rbeat;
  logic [W-1:0] r_seq;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return !m_search && (m_frame_left == 0) && !m_hold;
  endfunction

  task automatic model_reset();
    m_search = 1'b0; m_hold = 1'b0;
    m_search_left = 0; m_frame_left = 0; m_hold_left = 0;
    m_lock = 0; m_miss = 0;
  endtask

  task automatic start_hold();
    m_hold      = 1'b1;
    m_hold_left = int'(holdoff);
  endtask

  task automatic clr_obs();
    obs_obeats = 0; obs_olast = 0; obs_olast_idx = 0; obs_order_bad = 0;
    obs_first = '0; obs_prev = '0;
  endtask

  task automatic compare_all();
    int fl;
    bit lock_now, in_frame, e_ov, e_rr, e_ol;
    fl       = (frame_len == 16'd0) ? 1 : int'(frame_len);
    lock_now = m_search && r_tlast;
    in_frame = (m_frame_left > 0) || lock_now;
    e_ov     = in_frame && r_tvalid;
    e_rr     = in_frame ? o_tready : 1'b1;
    e_ol     = e_ov && ((m_frame_left > 0) ? (m_frame_left == 1) : (fl == 1));
    chk("o_tvalid", o_tvalid, e_ov);
    chk("r_tready", r_tready, e_rr);
    chk("o_tlast",  o_tlast,  e_ol);
    if (e_ov) chk("o_tdata", o_tdata, r_tdata);
    chk("d_tdata",  d_tdata,  s_tdata);
    chk("d_tvalid", d_tvalid, s_tvalid);
    chk("s_tready", s_tready, d_tready);
    chk("d_tlast",  d_tlast,  s_tlast && enable && m_idle());
    chk("locked",   locked,   m_frame_left > 0);
    chk("busy",     busy,     !m_idle());
    chk("lock_cnt", lock_cnt, m_lock);
    chk("miss_cnt", miss_cnt, m_miss);
    p_rbeat    = r_tvalid && e_rr;
    p_shs      = s_tvalid && d_tready;
    obs_dtlast = d_tlast;
    last_rbeat = r_tvalid && r_tready;
    if (o_tvalid && o_tready) begin
      obs_obeats++;
      if (obs_obeats == 1) obs_first = o_tdata;
      else if (o_tdata != obs_prev + 1) obs_order_bad++;
      obs_prev = o_tdata;
      if (o_tlast) begin
        obs_olast++;
        obs_olast_idx = obs_obeats;
      end
    end
  endtask

  task automatic model_update();
    int fl;
    bit li, mi;
    li = 1'b0; mi = 1'b0;
    fl = (frame_len == 16'd0) ? 1 : int'(frame_len);
    if (m_idle()) begin
      if (p_shs && s_tlast && enable) begin
        m_search      = 1'b1;
        m_search_left = (timeout == 16'd0) ? 1 : int'(timeout);
      end
    end else if (m_search) begin
      if (p_rbeat && r_tlast) begin
        li = 1'b1; m_search = 1'b0;
        if (fl == 1) start_hold();
        else m_frame_left = fl - 1;
      end else if (!enable) begin
        m_search = 1'b0;
      end else if (p_rbeat) begin
        m_search_left--;
        if (m_search_left == 0) begin mi = 1'b1; m_search = 1'b0; end
      end
    end else if (m_frame_left > 0) begin
      if (p_rbeat) begin
        m_frame_left--;
        if (m_frame_left == 0) start_hold();
      end
    end else if (m_hold) begin
      if (m_hold_left == 0) m_hold = 1'b0;
      else if (p_rbeat) begin
        m_hold_left--;
        if (m_hold_left == 0) m_hold = 1'b0;
      end
    end
    if (clear) begin
      m_lock = 0; m_miss = 0;
    end else begin
      if (li && m_lock < 65535) m_lock++;
      if (mi && m_miss < 65535) m_miss++;
    end
  endtask

  // Entered at posedge+1 with inputs set; checks at +3, advances the model at the edge.
  task automatic tick();
    #2;
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic trigger();
    s_tvalid = 1'b1; s_tlast = 1'b1; d_tready = 1'b1; r_tvalid = 1'b0;
    tick();
    s_tlast = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    frame_len = 16'd100; timeout = 16'd400; holdoff = 16'd50;
    s_tdata = 32'd0; s_tlast = 1'b0; s_tvalid = 1'b0; d_tready = 1'b1;
    r_tdata = 32'd0; r_tlast = 1'b0; r_tvalid = 1'b0; o_tready = 1'b1;
    r_seq = 32'd0;
    model_reset(); clr_obs();
    @(posedge clk); #1;
    compare_all();
    @(posedge clk); #1;
    reset = 1'b0;

    // Lock on the 250th r-beat, 100-sample frame.
    clr_obs();
    trigger();
    chk("lock_arm", busy, 1'b1);
    r_tvalid = 1'b1;
    for (int i = 1; i <= 349; i++) begin
      r_tlast = (i == 250);
      r_tdata = 32'(i);
      tick();
    end
    r_tlast = 1'b0;
    chk("lock_cnt1",   lock_cnt, 16'd1);
    chk("lock_beats",  obs_obeats, 100);
    chk("lock_first",  obs_first, 32'd250);
    chk("lock_nlast",  obs_olast, 1);
    chk("lock_lastix", obs_olast_idx, 100);
    chk("lock_order",  obs_order_bad, 0);

    // Holdoff of 50: trigger at beat 10 stripped, at beat 60 passes.
    s_tvalid = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      s_tlast = (i == 10) || (i == 60);
      r_tdata = 32'(1000 + i);
      tick();
      if (i == 10) chk("ho_strip", obs_dtlast, 1'b0);
      if (i == 60) chk("ho_pass",  obs_dtlast, 1'b1);
    end
    s_tlast = 1'b0;
    chk("ho_arm", busy, 1'b1);

    // Timeout after exactly 400 beats without r_tlast.
    clr_obs();
    for (int i = 1; i <= 400; i++) begin
      r_tdata = 32'(i);
      tick();
      if (i == 399) chk("to_busy", busy, 1'b1);
    end
    chk("to_idle",  busy, 1'b0);
    chk("to_miss",  miss_cnt, 16'd1);
    chk("to_noout", obs_obeats, 0);

    // Back-pressure: 64-sample frame with o_tready low ~30% of cycles.
    frame_len = 16'd64; holdoff = 16'd0;
    clr_obs();
    trigger();
    r_seq = 32'd5000;
    for (int c = 0; c < 2000 && obs_obeats < 64; c++) begin
      r_tvalid = ($urandom % 4) != 0;
      o_tready = ($urandom % 10) >= 3;
      r_tlast  = (obs_obeats == 0);
      r_tdata  = r_seq;
      tick();
      if (last_rbeat) r_seq = r_seq + 32'd1;
    end
    o_tready = 1'b1; r_tvalid = 1'b0; r_tlast = 1'b0;
    tick(); tick();
    chk("bp_beats",  obs_obeats, 64);
    chk("bp_first",  obs_first, 32'd5000);
    chk("bp_nlast",  obs_olast, 1);
    chk("bp_lastix", obs_olast_idx, 64);
    chk("bp_order",  obs_order_bad, 0);
    chk("bp_idle",   busy, 1'b0);

    // frame_len 0 behaves as a single-sample frame.
    frame_len = 16'd0;
    clr_obs();
    trigger();
    r_tvalid = 1'b1; r_tlast = 1'b1; r_tdata = 32'd77;
    tick();
    r_tvalid = 1'b0; r_tlast = 1'b0;
    tick();
    chk("fl0_beats", obs_obeats, 1);
    chk("fl0_last",  obs_olast, 1);
    chk("fl0_idle",  busy, 1'b0);

    // Enable drop while armed: back to idle, no miss.
    frame_len = 16'd8; timeout = 16'd400;
    trigger();
    r_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b0; r_tvalid = 1'b0;
    tick();
    enable = 1'b1;
    chk("en_idle", busy, 1'b0);
    chk("en_miss", miss_cnt, 16'd1);

    // Clear coincident with a lock.
    frame_len = 16'd1;
    trigger();
    r_tvalid = 1'b1; r_tlast = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; r_tvalid = 1'b0; r_tlast = 1'b0;
    chk("clr_lock", lock_cnt, 16'd0);
    chk("clr_miss", miss_cnt, 16'd0);
    tick();

    // Reset at sample 40 of a 100-sample frame, then re-arm.
    frame_len = 16'd100; holdoff = 16'd3;
    clr_obs();
    trigger();
    r_tvalid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      r_tlast = (i == 1);
      r_tdata = 32'(i);
      tick();
    end
    r_tlast = 1'b0;
    chk("rst_pre_beats", obs_obeats, 40);
    do_reset();
    chk("rst_nolast", obs_olast, 0);
    chk("rst_locked", locked, 1'b0);
    trigger();
    chk("rst_rearm", busy, 1'b1);

    // Random traffic; settings only change while the model is idle.
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 600) == 0) begin
        do_reset();
      end else begin
        if (m_idle() && ($urandom % 8) == 0) begin
          frame_len = 16'($urandom_range(0, 5));
          timeout   = 16'($urandom_range(0, 9));
          holdoff   = 16'($urandom_range(0, 4));
        end
        enable   = ($urandom % 16) != 0;
        clear    = ($urandom % 32) == 0;
        s_tdata  = $urandom;
        s_tvalid = ($urandom % 2) != 0;
        s_tlast  = ($urandom % 4) == 0;
        d_tready = ($urandom % 4) != 0;
        r_tdata  = $urandom;
        r_tvalid = ($urandom % 4) != 0;
        r_tlast  = ($urandom % 16) == 0;
        o_tready = ($urandom % 4) != 0;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
